adder_16_bit: RTL and testbench
===============================

Name: adder_16_bit

Overview:
16-bit unsigned adder with carry-in and carry-out, outputs registered on the system clock. Used as a datapath arithmetic primitive. The sum is built from four 4-bit carry-lookahead groups chained by a group-level lookahead unit, then captured in an output register. Downstream logic sees result and carry one clock after operands are presented.

Parameters:
none; width is fixed at 16 bits.

Ports:
clk    input   1   system clock, rising-edge active
rst_n  input   1   asynchronous active-low reset
a      input   16  operand A, unsigned
b      input   16  operand B, unsigned
c_up   input   1   carry-in, weight 1
y      output  16  registered sum bits [15:0]
Co     output  1   registered carry-out, i.e. sum bit 16

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset: while rst_n=0, y=16'h0000 and Co=0 immediately, independent of clk. Release is synchronous to the next rising clk; the first capture happens on the first rising edge with rst_n=1.
- Arithmetic: {Co_next, y_next} = a + b + c_up, computed in 17 bits. No saturation. Overflow wraps y modulo 2^16 and sets Co.
- Structure:
  - Per bit: generate g=a&b, propagate p=a^b.
  - Four 4-bit CLA groups, each producing group G/P and internal carries.
  - A second-level lookahead produces group carry-ins c4, c8, c12 and c16 from c_up.
  - Sum bit = p ^ carry_in_of_bit.
  - Ripple-only implementation is not acceptable.
- Timing:
  - The combinational sum is registered on every rising clk edge; no enable.
  - Latency is exactly 1 cycle: inputs valid before edge N appear on y/Co after edge N.
  - Outputs hold between edges.
  - Inputs are sampled only at rising edges; input glitches between edges have no effect.
- Reset mid-operation: asserting rst_n clears y/Co at once. A result captured before reset is lost and is not replayed after release.
- X/Z on inputs is not handled; inputs are assumed 2-state at the sampling edge.
- Outputs never depend combinationally on inputs. Only the register drives y and Co.

Test Plan:
- Reset: rst_n=0 with a=16'hFFFF, b=16'h0001, c_up=1, toggle clk -> y=0, Co=0 throughout. Release reset, one rising edge -> y=16'h0001, Co=1.
- Basic add: a=16'h1234, b=16'h4321, c_up=0, one edge -> y=16'h5555, Co=0. Then set c_up=1, next edge -> y=16'h5556, Co=0.
- Full carry chain: a=16'hFFFF, b=16'h0000, c_up=1 -> y=16'h0000, Co=1. Also a=16'h00FF, b=16'h0001, c_up=0 -> y=16'h0100, Co=0 (carry across CLA group boundary).
- Max/overflow: a=16'hFFFF, b=16'hFFFF, c_up=1 -> y=16'hFFFF, Co=1. Also a=16'h8000, b=16'h8000, c_up=0 -> y=16'h0000, Co=1.
- Random regression: 100 random {a,b} pairs with c_up=0, plus 100 with random c_up, one edge apart. Compare {Co,y} to the 17-bit model a+b+c_up one cycle later -> 0 mismatches.
- Async reset mid-stream: drive random operands every cycle, then pulse rst_n low between edges -> y/Co go to 0 before the next edge. After release, the first result reflects operands at the first post-release edge.

Source files
------------

// File: rtl/adder_16_bit.sv
`default_nettype none
// ============================================================================
// Module   : adder_16_bit
// Brief    : 16-bit registered adder built from four 4-bit CLA groups and a
//            second-level lookahead unit.
// Revision : 1.0 - initial release
// ============================================================================

module adder_16_bit_cla4 (
   input  logic [3:0] p,
   input  logic [3:0] g,
   input  logic       cin,
   output logic [3:0] c,
   output logic       gg,
   output logic       gp
);

   // c[i] is the carry into bit i of this group
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

   assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
   assign gp = &p;

endmodule

module adder_16_bit_lcu (
   input  logic [3:0] gg,
   input  logic [3:0] gp,
   input  logic       c0,
   output logic [4:1] cg
);

   // cg[k] is the carry out of group k-1 (c4, c8, c12, c16)
   assign cg[1] = gg[0] | (gp[0] & c0);
   assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c0);
   assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & c0);
   assign cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0])
                | (gp[3] & gp[2] & gp[1] & gp[0] & c0);

endmodule

module adder_16_bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        c_up,
   output logic [15:0] y,
   output logic        Co
);

   localparam int c_GROUPS = 4;

   logic [15:0]         w_p;
   logic [15:0]         w_g;
   logic [15:0]         w_carry;
   logic [15:0]         w_sum;
   logic [c_GROUPS-1:0] w_gg;
   logic [c_GROUPS-1:0] w_gp;
   logic [c_GROUPS:1]   w_cg;
   logic [c_GROUPS-1:0] w_gcin;

   logic [15:0]         r_y;
   logic                r_co;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Group carry-ins come from the lookahead unit, never from a ripple chain
   assign w_gcin = {w_cg[3:1], c_up};

   generate
      for (genvar gi = 0; gi < c_GROUPS; gi++) begin : g_group
         adder_16_bit_cla4 u_cla4 (
            .p   (w_p[gi*4 +: 4]),
            .g   (w_g[gi*4 +: 4]),
            .cin (w_gcin[gi]),
            .c   (w_carry[gi*4 +: 4]),
            .gg  (w_gg[gi]),
            .gp  (w_gp[gi])
         );
      end
   endgenerate

   adder_16_bit_lcu u_lcu (
      .gg (w_gg),
      .gp (w_gp),
      .c0 (c_up),
      .cg (w_cg)
   );

   assign w_sum = w_p ^ w_carry;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y  <= 16'h0000;
         r_co <= 1'b0;
      end else begin
         r_y  <= w_sum;
         r_co <= w_cg[4];
      end
   end

   assign y  = r_y;
   assign Co = r_co;

endmodule

`default_nettype wire

// File: tb/tb_adder_16_bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_16_bit
// Brief    : Self-checking bench for adder_16_bit (vectors, random, reset).
// Revision : 1.0 - initial release
// ============================================================================

module tb_adder_16_bit;

   logic        clk;
   logic        rst_n;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_up;
   logic [15:0] y;
   logic        Co;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic [15:0] exp_y;
      logic        exp_co;
      string       name;
   } vec_t;

   vec_t vecs[8];

   adder_16_bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .c_up  (c_up),
      .y     (y),
      .Co    (Co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] z,
                                         input logic cin);
      return 17'(x) + 17'(z) + 17'(cin);
   endfunction

   task automatic check(input string name, input logic [16:0] exp);
      n_total++;
      if ({Co, y} === exp) n_pass++;
      else $display("FAIL %s: got Co=%b y=%h, expected Co=%b y=%h",
                    name, Co, y, exp[16], exp[15:0]);
   endtask

   // Present operands, take one rising edge, sample just after it
   task automatic apply(input logic [15:0] x, input logic [15:0] z, input logic cin);
      a = x; b = z; c_up = cin;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] ra, rb;
   logic        rc;
   logic [16:0] held;

   initial begin
      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic"};
      vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, "basic_cin"};
      vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "full_chain"};
      vecs[3] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "group_cross"};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "max"};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "msb_ovf"};
      vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, "group2_cross"};
      vecs[7] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, "zero"};

      // Reset held with live operands: outputs stay zero across edges
      rst_n = 1'b0; a = 16'hFFFF; b = 16'h0001; c_up = 1'b1;
      #1;
      check("reset_async", 17'h0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("reset_hold", 17'h0);
      end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_release", 17'h10001);

      foreach (vecs[i]) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].c);
         check(vecs[i].name, {vecs[i].exp_co, vecs[i].exp_y});
      end

      // Glitches between edges must not reach the outputs
      apply(16'h1111, 16'h2222, 1'b0);
      held = model(16'h1111, 16'h2222, 1'b0);
      a = 16'hFFFF; b = 16'hFFFF; c_up = 1'b1;
      #2;
      check("glitch_hold", held);
      a = 16'h1111; b = 16'h2222; c_up = 1'b0;
      @(posedge clk); #1;
      check("glitch_recapture", held);

      for (int i = 0; i < 200; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = (i < 100) ? 1'b0 : 1'($urandom);
         apply(ra, rb, rc);
         check(i < 100 ? "rand_nocin" : "rand_cin", model(ra, rb, rc));
      end

      // Async reset pulse mid-cycle, then first post-release capture
      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         apply(ra, rb, rc);
         check("stream", model(ra, rb, rc));
      end
      apply(16'hFFFF, 16'hFFFF, 1'b1);
      check("pre_reset", 17'h1FFFF);
      #2 rst_n = 1'b0;
      #1;
      check("mid_reset_clear", 17'h0);
      @(posedge clk); #1;
      check("mid_reset_hold", 17'h0);
      #2 rst_n = 1'b1;
      ra = 16'h7F00; rb = 16'h0180; rc = 1'b1;
      apply(ra, rb, rc);
      check("post_release", model(ra, rb, rc));
      apply(16'h0001, 16'h0002, 1'b0);
      check("post_release_next", 17'h00003);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
